// File: rtl/exec_stage_if.sv
// Issue / register-file write-back bundle for exec_stage.
// master = issue side driving operations, slave = exec_stage.
interface exec_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              Valid_i;
  logic              Ready_o;
  logic [2:0]        Op_i;
  logic [DATA_W-1:0] Rs_i;
  logic [DATA_W-1:0] Rs2_i;
  logic [DATA_W-1:0] Imm_i;
  logic              ImmSel_i;
  logic [ADDR_W-1:0] Rd_i;
  logic              RegWrt_o;
  logic [ADDR_W-1:0] Rd_o;
  logic [DATA_W-1:0] Dat_o;
  logic              Busy_o;
  logic              Zero_o;
  logic              Carry_o;

  modport master (
    output Valid_i, Op_i, Rs_i, Rs2_i, Imm_i, ImmSel_i, Rd_i,
    input  Ready_o, RegWrt_o, Rd_o, Dat_o, Busy_o, Zero_o, Carry_o
  );

  modport slave (
    input  Valid_i, Op_i, Rs_i, Rs2_i, Imm_i, ImmSel_i, Rd_i,
    output Ready_o, RegWrt_o, Rd_o, Dat_o, Busy_o, Zero_o, Carry_o
  );
endinterface

// File: rtl/exec_stage.sv
// Execute/write-back stage: single-cycle ALU feeding the register-file write port.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (op 111).
module exec_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic         Clk_i,
  input  logic         Rst_i,
  input  logic         ClkEn_i,
  exec_stage_if.slave  io
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WB} state_e;

  state_e            state_q;
  logic              regwrt_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] dat_q;
  logic              zero_q, carry_q;

  logic [DATA_W-1:0] opa, opb, res;
  logic              cy, acc;

  assign opa        = io.Rs_i;
  assign opb        = io.ImmSel_i ? io.Imm_i : io.Rs2_i;
  assign io.Ready_o = ClkEn_i && (state_q == ST_IDLE);
  assign acc        = io.Valid_i && io.Ready_o;

  always_comb begin
    res = '0;
    cy  = 1'b0;
    case (io.Op_i)
      OP_ADD: {cy, res} = {1'b0, opa} + {1'b0, opb};
      // Borrow lands in the extra top bit exactly when A < B.
      OP_SUB: {cy, res} = {1'b0, opa} - {1'b0, opb};
      OP_AND: res = opa & opb;
      OP_OR:  res = opa | opb;
      OP_XOR: res = opa ^ opb;
      OP_SHL: res = opa << opb[SH_W-1:0];
      OP_SHR: res = opa >> opb[SH_W-1:0];
      default: ;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic [2*DATA_W-1:0] mcand_q, prod_q, prod_nxt;
  logic [DATA_W-1:0]   mplier_q;
  logic [SH_W-1:0]     cnt_q;
  logic [ADDR_W-1:0]   mrd_q;

  assign prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign io.Busy_o = (state_q != ST_IDLE);
`else
  assign io.Busy_o = 1'b0;
`endif

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_q  <= ST_IDLE;
      regwrt_q <= 1'b0;
      rd_q     <= '0;
      dat_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mrd_q    <= '0;
`endif
    end else if (ClkEn_i) begin
      regwrt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acc && io.Op_i != OP_MUL) begin
            regwrt_q <= 1'b1;
            rd_q     <= io.Rd_i;
            dat_q    <= res;
            zero_q   <= (res == '0);
            carry_q  <= cy;
          end
`ifdef EXEC_MUL_EN
          else if (acc) begin
            state_q  <= ST_MUL;
            mcand_q  <= {{DATA_W{1'b0}}, opa};
            mplier_q <= opb;
            prod_q   <= '0;
            cnt_q    <= '0;
            mrd_q    <= io.Rd_i;
          end
`endif
        end
`ifdef EXEC_MUL_EN
        ST_MUL: begin
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Last partial product: register the write so it is visible during WB.
          if (cnt_q == SH_W'(DATA_W-1)) begin
            state_q  <= ST_WB;
            regwrt_q <= 1'b1;
            rd_q     <= mrd_q;
            dat_q    <= prod_nxt[DATA_W-1:0];
            zero_q   <= (prod_nxt[DATA_W-1:0] == '0);
            carry_q  <= |prod_nxt[2*DATA_W-1:DATA_W];
          end
        end
        ST_WB: state_q <= ST_IDLE;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.RegWrt_o = regwrt_q;
  assign io.Rd_o     = rd_q;
  assign io.Dat_o    = dat_q;
  assign io.Zero_o   = zero_q;
  assign io.Carry_o  = carry_q;
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage; MUL checks follow the EXEC_MUL_EN build option.
module tb_exec_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic clken;
  int   n_run = 0;
  int   n_fail = 0;

  exec_stage_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  exec_stage #(.DATA_W(8), .ADDR_W(3)) dut (
    .Clk_i  (clk),
    .Rst_i  (rst_n),
    .ClkEn_i(clken),
    .io     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b2,
                       input logic [7:0] imm, input logic sel, input logic [2:0] rd);
    bus.Valid_i  = 1'b1;
    bus.Op_i     = op;
    bus.Rs_i     = a;
    bus.Rs2_i    = b2;
    bus.Imm_i    = imm;
    bus.ImmSel_i = sel;
    bus.Rd_i     = rd;
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] rd, input logic [7:0] dat,
                        input logic z, input logic c);
    chk({tag, ".wrt"},   32'(bus.RegWrt_o), 32'd1);
    chk({tag, ".rd"},    32'(bus.Rd_o), 32'(rd));
    chk({tag, ".dat"},   32'(bus.Dat_o), 32'(dat));
    chk({tag, ".zero"},  32'(bus.Zero_o), 32'(z));
    chk({tag, ".carry"}, 32'(bus.Carry_o), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    clken = 1'b1;
    bus.Valid_i = 1'b0; bus.Op_i = '0; bus.Rs_i = '0; bus.Rs2_i = '0;
    bus.Imm_i = '0; bus.ImmSel_i = 1'b0; bus.Rd_i = '0;
    step(); step();
    chk("rst.wrt", 32'(bus.RegWrt_o), 0);
    chk("rst.rd",  32'(bus.Rd_o), 0);
    chk("rst.dat", 32'(bus.Dat_o), 0);
    chk("rst.busy", 32'(bus.Busy_o), 0);
    chk("rst.zc",  32'({bus.Zero_o, bus.Carry_o}), 0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready", 32'(bus.Ready_o), 1);

    // ADD FF+01 wraps to 0 with carry out
    issue(3'b000, 8'hFF, 8'h01, 8'h77, 1'b0, 3'd3);
    step();
    chk_wr("add", 3'd3, 8'h00, 1'b1, 1'b1);

`ifndef EXEC_MUL_EN
    issue(3'b111, 8'h10, 8'h11, 8'h00, 1'b0, 3'd5);
    chk("nomul.ready", 32'(bus.Ready_o), 1);
    step();
    bus.Valid_i = 1'b0;
    chk("nomul.wrt",  32'(bus.RegWrt_o), 0);
    chk("nomul.busy", 32'(bus.Busy_o), 0);
    chk("nomul.hold", 32'({bus.Zero_o, bus.Carry_o, bus.Dat_o}), 32'({2'b11, 8'h00}));
    step();
    chk("nomul.wrt2", 32'(bus.RegWrt_o), 0);
    chk("nomul.busy2", 32'(bus.Busy_o), 0);
`endif

    // SUB with immediate; Rs2 carries a distractor
    issue(3'b001, 8'h05, 8'hAA, 8'h07, 1'b1, 3'd2);
    step();
    chk_wr("sub", 3'd2, 8'hFE, 1'b0, 1'b1);

    issue(3'b100, 8'hAA, 8'h5A, 8'h00, 1'b0, 3'd1);
    step();
    chk_wr("xor", 3'd1, 8'hF0, 1'b0, 1'b0);
    issue(3'b101, 8'h81, 8'h00, 8'h09, 1'b1, 3'd7);
    step();
    chk_wr("shl", 3'd7, 8'h02, 1'b0, 1'b0);

    bus.Valid_i = 1'b0;
    step();
    chk("idle.wrt", 32'(bus.RegWrt_o), 0);
    chk("idle.hold", 32'({bus.Rd_o, bus.Dat_o}), 32'({3'd7, 8'h02}));

    issue(3'b110, 8'h80, 8'h0F, 8'h00, 1'b0, 3'd4);
    step();
    chk_wr("shr", 3'd4, 8'h01, 1'b0, 1'b0);
    issue(3'b010, 8'h3C, 8'hF0, 8'h00, 1'b0, 3'd6);
    step();
    chk_wr("and", 3'd6, 8'h30, 1'b0, 1'b0);
    issue(3'b011, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    step();
    chk_wr("or0", 3'd0, 8'h00, 1'b1, 1'b0);
    bus.Valid_i = 1'b0;
    step();

    // Clock enable low: nothing accepted, state frozen
    clken = 1'b0;
    issue(3'b000, 8'h01, 8'h01, 8'h00, 1'b0, 3'd5);
    #1;
    chk("ce.ready", 32'(bus.Ready_o), 0);
    step(); step();
    chk("ce.wrt", 32'(bus.RegWrt_o), 0);
    chk("ce.hold", 32'({bus.Rd_o, bus.Dat_o, bus.Zero_o}), 32'({3'd0, 8'h00, 1'b1}));
    clken = 1'b1;
    bus.Valid_i = 1'b0;
    step();

`ifdef EXEC_MUL_EN
    issue(3'b111, 8'h10, 8'h11, 8'h00, 1'b0, 3'd5);
    step();
    issue(3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b1, 3'd1);
    bus.Valid_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("mul.ready%0d", i), 32'(bus.Ready_o), 0);
      chk($sformatf("mul.busy%0d", i), 32'(bus.Busy_o), 1);
      chk($sformatf("mul.wrt%0d", i), 32'(bus.RegWrt_o), 32'(i == 8));
      if (i == 8) chk_wr("mul", 3'd5, 8'h10, 1'b0, 1'b1);
      step();
    end
    chk("mul.ready_after", 32'(bus.Ready_o), 1);
    chk("mul.busy_after", 32'(bus.Busy_o), 0);
    chk("mul.wrt_after", 32'(bus.RegWrt_o), 0);

    // Pause mid-multiply; iteration resumes where it stopped
    issue(3'b111, 8'h03, 8'h00, 8'h05, 1'b1, 3'd0);
    step();
    bus.Valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    clken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mulp.pause%0d", i), 32'({bus.Busy_o, bus.RegWrt_o, bus.Ready_o}), 32'b100);
    end
    clken = 1'b1;
    for (int i = 3; i < 9; i++) begin
      chk($sformatf("mulp.wrt%0d", i), 32'(bus.RegWrt_o), 32'(i == 8));
      if (i == 8) chk_wr("mulp", 3'd0, 8'h0F, 1'b0, 1'b0);
      step();
    end
`endif

    // Reset in the middle of a multiply: outputs clear, no write follows
    issue(3'b111, 8'h07, 8'h09, 8'h00, 1'b0, 3'd6);
    step();
    bus.Valid_i = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("rstm.out", 32'({bus.RegWrt_o, bus.Busy_o, bus.Zero_o, bus.Carry_o, bus.Rd_o, bus.Dat_o}), 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("rstm.nowrt%0d", i), 32'({bus.RegWrt_o, bus.Busy_o}), 0);
    end

    issue(3'b000, 8'h03, 8'h04, 8'h00, 1'b0, 3'd2);
    step();
    bus.Valid_i = 1'b0;
    chk_wr("post", 3'd2, 8'h07, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
